// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: shared opcodes, status codes, FSM states and Wishbone cycle-type constants.
package wb_cmd_pkg;
  typedef enum logic [2:0] {OP_WR = 3'd0, OP_RD = 3'd1, OP_BURST = 3'd2, OP_RPT = 3'd3, OP_POLL = 3'd4} op_e;
  typedef enum logic [1:0] {STS_OK = 2'd0, STS_ERR = 2'd1, STS_RTY = 2'd2, STS_TMO = 2'd3} sts_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DONE} state_e;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
endpackage

// File: rtl/wb_cmd_if.sv
// wb_cmd_if: command/response/status streams plus the Wishbone B3 master bus.
interface wb_cmd_if #(parameter int AW = 32, parameter int DW = 32, parameter int LEN_W = 8);
  localparam int SW = DW / 8;
  logic cmd_valid, cmd_ready;
  wb_cmd_pkg::op_e cmd_op;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat, cmd_mask;
  logic [SW-1:0] cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_dat;
  logic sts_valid;
  wb_cmd_pkg::sts_e sts_code;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;
  logic [SW-1:0] wbm_sel_o;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [2:0] wbm_cti_o;
  logic [1:0] wbm_bte_o;
  modport master (
    input cmd_valid, cmd_op, cmd_adr, cmd_dat, cmd_mask, cmd_sel, cmd_len, rsp_ready,
    input wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_last, sts_valid, sts_code,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_adr, cmd_dat, cmd_mask, cmd_sel, cmd_len, rsp_ready,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input cmd_ready, rsp_valid, rsp_dat, rsp_last, sts_valid, sts_code,
    input wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o
  );
endinterface

// File: rtl/wb_cmd_rsp_slot.sv
// wb_cmd_rsp_slot: one-deep valid/ready response register; push may coincide with a pop.
module wb_cmd_rsp_slot #(parameter int DW = 32) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          push_last,
  input  logic          ready,
  output logic          full,
  output logic [DW-1:0] dat,
  output logic          last
);
  always_ff @(posedge clk_i)
    if (rst_i) full <= 1'b0;
    else full <= push ? 1'b1 : full && !ready;
  always_ff @(posedge clk_i)
    if (push) begin
      dat <= push_dat;
      last <= push_last;
    end
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone B3 master executing write/read/burst/repeat/poll commands.
module wb_cmd_master import wb_cmd_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LEN_W = 8,
  parameter int MAX_RETRY = 4,
  parameter int POLL_MAX = 1024
) (
  input logic clk_i,
  input logic rst_i,
  wb_cmd_if.master bus
);
  localparam int SW = DW / 8;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  state_e state_q, state_d;
  op_e op_q, op_d;
  sts_e sts_q, sts_d;
  logic cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d, mask_q, mask_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [2:0] cti_q, cti_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [RW-1:0] rty_q, rty_d;
  logic [PW-1:0] poll_q, poll_d;
  logic push, push_last, full, hit, last_beat, tmo;
  // A read strobe is only raised once the slot is known to be empty, so an ack can always push.
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    sts_d = sts_q;
    cyc_d = cyc_q;
    stb_d = stb_q;
    we_d = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    mask_d = mask_q;
    sel_d = sel_q;
    cti_d = cti_q;
    left_d = left_q;
    rty_d = rty_q;
    poll_d = poll_q;
    push = 1'b0;
    push_last = 1'b0;
    hit = ((bus.wbm_dat_i ^ dat_q) & mask_q) == '0;
    last_beat = left_q == '0;
    tmo = poll_q == PW'(POLL_MAX - 1);
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        state_d = S_REQ;
        op_d = bus.cmd_op;
        sts_d = STS_OK;
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d = bus.cmd_op == OP_WR;
        adr_d = bus.cmd_adr;
        dat_d = bus.cmd_dat;
        mask_d = bus.cmd_mask;
        sel_d = bus.cmd_sel;
        left_d = (bus.cmd_op == OP_BURST || bus.cmd_op == OP_RPT) && bus.cmd_len != '0 ? bus.cmd_len - LEN_W'(1) : '0;
        cti_d = bus.cmd_op != OP_BURST ? CTI_CLASSIC : bus.cmd_len > LEN_W'(1) ? CTI_INCR : CTI_EOB;
        rty_d = '0;
        poll_d = '0;
      end
      S_REQ: if (bus.wbm_ack_i) begin
        stb_d = 1'b0;
        rty_d = '0;
        push = !we_q && (op_q != OP_POLL || hit);
        push_last = op_q == OP_POLL || last_beat;
        if (we_q || (op_q == OP_POLL ? hit : last_beat)) begin
          state_d = S_DONE;
          cyc_d = 1'b0;
        end else if (op_q == OP_POLL) begin
          state_d = tmo ? S_DONE : S_HOLD;
          cyc_d = !tmo;
          sts_d = tmo ? STS_TMO : STS_OK;
          poll_d = poll_q + PW'(1);
        end else begin
          state_d = S_HOLD;
          left_d = left_q - LEN_W'(1);
          adr_d = op_q == OP_BURST ? adr_q + AW'(SW) : adr_q;
          cti_d = op_q != OP_BURST ? CTI_CLASSIC : left_q == LEN_W'(1) ? CTI_EOB : CTI_INCR;
        end
      end else if (bus.wbm_err_i) begin
        state_d = S_DONE;
        cyc_d = 1'b0;
        stb_d = 1'b0;
        sts_d = STS_ERR;
      end else if (bus.wbm_rty_i) begin
        stb_d = 1'b0;
        rty_d = rty_q + RW'(1);
        state_d = rty_q == RW'(MAX_RETRY) ? S_DONE : S_HOLD;
        cyc_d = rty_q != RW'(MAX_RETRY);
        sts_d = rty_q == RW'(MAX_RETRY) ? STS_RTY : STS_OK;
      end
      S_HOLD: if (!full || bus.rsp_ready) begin
        state_d = S_REQ;
        stb_d = 1'b1;
      end
      default: if (!full) state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q <= OP_WR;
      sts_q <= STS_OK;
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      mask_q <= '0;
      sel_q <= '0;
      cti_q <= CTI_CLASSIC;
      left_q <= '0;
      rty_q <= '0;
      poll_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sts_q <= sts_d;
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      we_q <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      mask_q <= mask_d;
      sel_q <= sel_d;
      cti_q <= cti_d;
      left_q <= left_d;
      rty_q <= rty_d;
      poll_q <= poll_d;
    end
  wb_cmd_rsp_slot #(.DW(DW)) u_slot (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(push),
    .push_dat(bus.wbm_dat_i),
    .push_last(push_last),
    .ready(bus.rsp_ready),
    .full(full),
    .dat(bus.rsp_dat),
    .last(bus.rsp_last)
  );
  assign bus.rsp_valid = full;
  assign bus.cmd_ready = state_q == S_IDLE && !rst_i;
  assign bus.sts_valid = state_q == S_DONE && !full;
  assign bus.sts_code = sts_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_we_o = we_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_cti_o = cti_q;
  assign bus.wbm_bte_o = BTE_LINEAR;
endmodule
